// File: rtl/apollo_mem_pkg.sv
// Shared types and defaults for the SDRAM port arbiter and its tag FIFO.
package apollo_mem_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Identifies which requester owns a command or a read return.
    typedef logic req_id_t;

endpackage

// File: rtl/mem_tag_fifo.sv
// Circular FIFO of requester ids, one entry per read in flight, in issue order.
module mem_tag_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        din,
    input  logic        pop,
    output logic        dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one SDRAM command port,
// routing in-order read returns back to the requester that issued each read.
module sdram_port_arbiter
    import apollo_mem_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CW   = $clog2(MAX_OUTSTANDING) + 1,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic [CW-1:0]     outstanding,
    output logic              err_orphan,
    output logic              dbg_state
);

    // Handshake: a requester holds read/write (and payload) until a cycle in
    // which its waitrequest is low; that cycle is the transfer. The SDRAM side
    // uses the same rule, and readdatavalid is a one-cycle, unstallable return.

    arb_state_t state;
    req_id_t    gnt;
    req_id_t    rr;

    logic can_read, elig0, elig1, rr_elig;
    logic g_read, g_write, cmd_read, cmd_write;
    logic granted, accept;
    logic fifo_head, fifo_empty, fifo_full, tag_valid;

    assign can_read = ~fifo_full;
    assign elig0    = m0_write | (m0_read & can_read);
    assign elig1    = m1_write | (m1_read & can_read);
    assign rr_elig  = rr ? elig1 : elig0;

    assign g_read    = gnt ? m1_read  : m0_read;
    assign g_write   = gnt ? m1_write : m0_write;
    // Read and write together from one requester is issued as a write.
    assign cmd_write = g_write;
    assign cmd_read  = g_read & ~g_write;

    assign granted      = reset_reset_n & (state == GRANT);
    assign s_read       = granted & cmd_read;
    assign s_write      = granted & cmd_write;
    assign s_address    = gnt ? m1_address    : m0_address;
    assign s_writedata  = gnt ? m1_writedata  : m0_writedata;
    assign s_byteenable = gnt ? m1_byteenable : m0_byteenable;

    assign m0_waitrequest = (granted && gnt == 1'b0) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (granted && gnt == 1'b1) ? s_waitrequest : 1'b1;

    assign accept = (s_read | s_write) & ~s_waitrequest;

    assign tag_valid        = reset_reset_n & s_readdatavalid & ~fifo_empty;
    assign m0_readdatavalid = tag_valid & (fifo_head == 1'b0);
    assign m1_readdatavalid = tag_valid & (fifo_head == 1'b1);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign dbg_state = state;

    mem_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (accept & cmd_read),
        .din   (gnt),
        .pop   (s_readdatavalid),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            rr         <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (s_readdatavalid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        gnt   <= rr_elig ? rr : ~rr;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        rr    <= ~gnt;
                        state <= IDLE;
                    end else if (!g_read && !g_write) begin
                        // Requester withdrew its command: give up the grant, keep rr.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: per-cycle vector table, directed multi-cycle
// sequences, then random traffic against a transaction-level model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int MAXO   = 8;
    localparam int CW     = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [CW-1:0]     outstanding;
    logic              err_orphan;
    logic              dbg_state;

    sdram_port_arbiter dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .outstanding      (outstanding),
        .err_orphan       (err_orphan),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_clk = ~clk_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Owners of reads accepted by the SDRAM port and not yet returned.
    logic [0:0] exp_q[$];

    typedef struct {
        logic rst, m0r, m0w, m1r, m1w, sw, rdv;
        logic e_srd, e_swr, e_src, e_w0, e_w1, e_v0, e_v1;
        int   e_out;
        logic e_orph;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, m0r, m0w, m1r, m1w, sw, rdv,
                                input logic e_srd, e_swr, e_src, e_w0, e_w1, e_v0, e_v1,
                                input int e_out, input logic e_orph);
        vec_t v;
        v.rst = rst; v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
        v.sw = sw; v.rdv = rdv;
        v.e_srd = e_srd; v.e_swr = e_swr; v.e_src = e_src; v.e_w0 = e_w0; v.e_w1 = e_w1;
        v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_out = e_out; v.e_orph = e_orph;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_cmd(input int m, input logic rd, input logic wr);
        if (m == 0) begin
            m0_read = rd; m0_write = wr;
        end else begin
            m1_read = rd; m1_write = wr;
        end
    endtask

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = ADDR_W'(32'h100); m1_address = ADDR_W'(32'h200);
        m0_writedata = 32'h0000_1111; m1_writedata = 32'h0000_2222;
        m0_byteenable = 4'hf; m1_byteenable = 4'hf;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = 32'hdead_beef;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        clear_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
    endtask

    // Holds a command until its waitrequest drops, with a cycle budget.
    task automatic do_cmd(input int m, input logic wr);
        logic done;
        done = 1'b0;
        s_waitrequest = 1'b0;
        set_cmd(m, !wr, wr);
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk_clk);
            if ((m == 0 ? m0_waitrequest : m1_waitrequest) == 1'b0) done = 1'b1;
            @(posedge clk_clk);
            #1;
        end
        set_cmd(m, 1'b0, 1'b0);
        chk("cmd_accept", done, 1'b1);
    endtask

    // ---------------- random-test model state ----------------
    logic              c_act[2], c_rd[2], c_wr[2];
    logic [ADDR_W-1:0] c_addr[2];
    logic [DATA_W-1:0] c_data[2];
    logic [BE_W-1:0]   c_be[2];
    int                c_wait[2], c_bypass[2];

    task automatic drive_masters();
        m0_read = c_act[0] & c_rd[0]; m0_write = c_act[0] & c_wr[0];
        m1_read = c_act[1] & c_rd[1]; m1_write = c_act[1] & c_wr[1];
        m0_address = c_addr[0]; m1_address = c_addr[1];
        m0_writedata = c_data[0]; m1_writedata = c_data[1];
        m0_byteenable = c_be[0]; m1_byteenable = c_be[1];
    endtask

    // ---------------- main sequence ----------------
    logic              wr_seen, rd_seen, g0, g1, rdv_now;
    logic [DATA_W-1:0] beat;
    logic [0:0]        owner;
    int                kind, gm, pre_size;

    initial begin
        reset_reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk_clk);
        #1;

        // rst m0r m0w m1r m1w sw rdv | srd swr src w0 w1 v0 v1 out orph
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,0)); // reset state
        tbl.push_back(mk(1,0,1,0,0,0,0, 0,0,0,1,1,0,0,0,0)); // m0 write: arbitration cycle
        tbl.push_back(mk(1,0,1,0,0,0,0, 0,1,0,0,1,0,0,0,0)); // command cycle
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0,1,1,0,0,0,0)); // both read continuously
        tbl.push_back(mk(1,1,0,1,0,0,0, 1,0,0,0,1,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0,1,1,0,0,1,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 1,0,1,1,0,0,0,1,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0,1,1,0,0,2,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 1,0,0,0,1,0,0,2,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0,1,1,0,0,3,0));
        tbl.push_back(mk(1,1,0,1,0,0,0, 1,0,1,1,0,0,0,3,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,4,0));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1,1,1,0,4,0)); // returns in order
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1,1,0,1,3,0));
        tbl.push_back(mk(1,0,0,1,0,1,0, 0,0,0,1,1,0,0,2,0)); // m1 read, slave stalls 3
        tbl.push_back(mk(1,0,0,1,0,1,0, 1,0,1,1,1,0,0,2,0));
        tbl.push_back(mk(1,0,0,1,0,1,0, 1,0,1,1,1,0,0,2,0));
        tbl.push_back(mk(1,0,0,1,0,1,0, 1,0,1,1,1,0,0,2,0));
        tbl.push_back(mk(1,0,0,1,0,0,0, 1,0,1,1,0,0,0,2,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,3,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,0,1,1,0,0,3,0)); // push and pop together
        tbl.push_back(mk(1,1,0,0,0,0,1, 1,0,0,0,1,1,0,3,0));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1,1,0,1,3,0));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1,1,0,1,2,0));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1,1,1,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,1, 0,0,0,1,1,0,0,0,0)); // orphan beat
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,1,0, 0,0,0,1,1,0,0,0,0)); // m0 withdraws in GRANT
        tbl.push_back(mk(1,0,0,0,0,1,0, 0,0,0,1,1,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,1,0,0, 0,0,0,1,1,0,0,0,0)); // rr unchanged: m0 first
        tbl.push_back(mk(1,0,1,0,1,0,0, 0,1,0,0,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0, 0,0,0,1,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0, 0,1,1,1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,0,0,1,1,0,0,0,0)); // read+write is a write
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,1,0,0,1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,1,1,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset_reset_n = tbl[i].rst;
            m0_read = tbl[i].m0r; m0_write = tbl[i].m0w;
            m1_read = tbl[i].m1r; m1_write = tbl[i].m1w;
            s_waitrequest = tbl[i].sw; s_readdatavalid = tbl[i].rdv;
            @(negedge clk_clk);
            chk($sformatf("vec%0d_s_read", i), s_read, tbl[i].e_srd);
            chk($sformatf("vec%0d_s_write", i), s_write, tbl[i].e_swr);
            chk($sformatf("vec%0d_m0_wait", i), m0_waitrequest, tbl[i].e_w0);
            chk($sformatf("vec%0d_m1_wait", i), m1_waitrequest, tbl[i].e_w1);
            chk($sformatf("vec%0d_m0_rdv", i), m0_readdatavalid, tbl[i].e_v0);
            chk($sformatf("vec%0d_m1_rdv", i), m1_readdatavalid, tbl[i].e_v1);
            chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].e_out);
            chk($sformatf("vec%0d_err_orphan", i), err_orphan, tbl[i].e_orph);
            if (tbl[i].e_srd || tbl[i].e_swr)
                chk($sformatf("vec%0d_s_address", i), s_address,
                    tbl[i].e_src ? 64'h200 : 64'h100);
            @(posedge clk_clk);
            #1;
        end

        // Fill to the read limit, then a 9th read must stall while a write passes.
        do_reset();
        for (int k = 0; k < MAXO; k++) do_cmd(k % 2, 1'b0);
        @(negedge clk_clk);
        chk("full_outstanding", outstanding, MAXO);
        @(posedge clk_clk);
        #1;
        set_cmd(0, 1'b1, 1'b0);
        set_cmd(1, 1'b0, 1'b1);
        wr_seen = 0; rd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_clk);
            if (!m0_waitrequest || s_read) rd_seen = 1;
            if (!m1_waitrequest && s_write) wr_seen = 1;
            @(posedge clk_clk);
            #1;
            if (wr_seen) set_cmd(1, 1'b0, 1'b0);
        end
        chk("full_write_passes", wr_seen, 1'b1);
        chk("full_read_stalls", rd_seen, 1'b0);
        set_cmd(0, 1'b0, 1'b0);
        for (int k = 0; k < MAXO; k++) begin
            beat = $urandom;
            s_readdatavalid = 1'b1; s_readdata = beat;
            @(negedge clk_clk);
            chk("drain_m0_rdv", m0_readdatavalid, (k % 2) == 0);
            chk("drain_m1_rdv", m1_readdatavalid, (k % 2) == 1);
            chk("drain_data", (k % 2) ? m1_readdata : m0_readdata, beat);
            chk("drain_outstanding", outstanding, MAXO - k);
            @(posedge clk_clk);
            #1;
        end
        s_readdatavalid = 1'b0;
        @(negedge clk_clk);
        chk("drain_empty", outstanding, 0);
        @(posedge clk_clk);
        #1;

        // Reset while granted with two reads in flight; a late return is an orphan.
        do_reset();
        do_cmd(0, 1'b0);
        do_cmd(1, 1'b0);
        set_cmd(0, 1'b1, 1'b0);
        s_waitrequest = 1'b1;
        @(posedge clk_clk);
        #1;
        @(negedge clk_clk);
        chk("rst_in_grant_state", dbg_state, 1'b1);
        chk("rst_in_grant_outstanding", outstanding, 2);
        chk("rst_in_grant_s_read", s_read, 1'b1);
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("rst_active_s_read", s_read, 1'b0);
        chk("rst_active_m0_wait", m0_waitrequest, 1'b1);
        @(posedge clk_clk);
        #1;
        set_cmd(0, 1'b0, 1'b0);
        s_waitrequest = 1'b0;
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        chk("rst_after_state", dbg_state, 1'b0);
        chk("rst_after_outstanding", outstanding, 0);
        @(posedge clk_clk);
        #1;
        s_readdatavalid = 1'b1;
        @(negedge clk_clk);
        chk("late_m0_rdv", m0_readdatavalid, 1'b0);
        chk("late_m1_rdv", m1_readdatavalid, 1'b0);
        @(posedge clk_clk);
        #1;
        s_readdatavalid = 1'b0;
        @(negedge clk_clk);
        chk("late_err_orphan", err_orphan, 1'b1);
        @(posedge clk_clk);
        #1;

        // Random traffic checked at transaction level.
        do_reset();
        for (int m = 0; m < 2; m++) begin
            c_act[m] = 0; c_rd[m] = 0; c_wr[m] = 0; c_addr[m] = '0;
            c_data[m] = '0; c_be[m] = '0; c_wait[m] = 0; c_bypass[m] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!c_act[m] && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 3);
                    c_act[m] = 1; c_wr[m] = (kind >= 2); c_rd[m] = (kind != 2);
                    c_addr[m] = ADDR_W'($urandom); c_data[m] = $urandom;
                    c_be[m] = BE_W'($urandom_range(0, 15));
                    c_wait[m] = 0; c_bypass[m] = 0;
                end
            end
            drive_masters();
            s_waitrequest = ($urandom_range(0, 3) == 0);
            rdv_now = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
            s_readdatavalid = rdv_now;
            s_readdata = $urandom;
            @(negedge clk_clk);
            pre_size = exp_q.size();
            chk("rand_outstanding", outstanding, pre_size);
            g0 = !m0_waitrequest;
            g1 = !m1_waitrequest;
            chk("rand_single_grant", g0 & g1, 1'b0);
            if ((s_read || s_write) && !s_waitrequest) begin
                gm = g1 ? 1 : 0;
                chk("rand_grant_owner", g0 | g1, 1'b1);
                chk("rand_req_active", c_act[gm], 1'b1);
                chk("rand_s_write", s_write, c_wr[gm]);
                chk("rand_s_read", s_read, c_rd[gm] & ~c_wr[gm]);
                chk("rand_s_address", s_address, c_addr[gm]);
                if (c_wr[gm]) begin
                    chk("rand_s_writedata", s_writedata, c_data[gm]);
                    chk("rand_s_byteenable", s_byteenable, c_be[gm]);
                    chk("rand_rr_bypass", c_bypass[gm] <= 1, 1'b1);
                end
                chk("rand_latency", c_wait[gm] <= 64, 1'b1);
                if (s_read) begin
                    chk("rand_read_limit", pre_size < MAXO, 1'b1);
                    exp_q.push_back(1'(gm));
                end
                if (c_act[1-gm] && c_wr[1-gm]) c_bypass[1-gm]++;
                c_act[gm] = 0;
            end
            for (int m = 0; m < 2; m++) if (c_act[m]) c_wait[m]++;
            if (rdv_now) begin
                owner = exp_q.pop_front();
                chk("rand_m0_rdv", m0_readdatavalid, owner == 1'b0);
                chk("rand_m1_rdv", m1_readdatavalid, owner == 1'b1);
                chk("rand_m0_data", m0_readdata, s_readdata);
                chk("rand_m1_data", m1_readdata, s_readdata);
            end else begin
                chk("rand_idle_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
            end
            @(posedge clk_clk);
            #1;
        end
        clear_inputs();
        @(negedge clk_clk);
        chk("rand_no_orphan", err_orphan, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width, multiple of 8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, maximum reads in flight, power of 2.
REQ-004 SHALL have port clk_clk, in, 1, sole clock; single clock domain.
REQ-005 SHALL have port reset_reset_n, in, 1, reset, synchronous, active-low.
REQ-006 SHALL have ports m0_address/m1_address, in, ADDR_W, requester address.
REQ-007 SHALL have ports m0_read/m1_read and m0_write/m1_write, in, 1, requester command strobes.
REQ-008 SHALL have ports m0_writedata/m1_writedata, in, DATA_W, and m0_byteenable/m1_byteenable, in, DATA_W/8, write payload.
REQ-009 SHALL have ports m0_waitrequest/m1_waitrequest, out, 1, command stall.
REQ-010 SHALL have ports m0_readdata/m1_readdata, out, DATA_W, and m0_readdatavalid/m1_readdatavalid, out, 1, read return.
REQ-011 SHALL have ports s_address, s_read, s_write, s_writedata, s_byteenable, out, widths as above, command to the SDRAM port.
REQ-012 SHALL have ports s_waitrequest, in, 1; s_readdata, in, DATA_W; s_readdatavalid, in, 1, SDRAM port response.
REQ-013 SHALL have port outstanding, out, log2(MAX_OUTSTANDING)+1, reads in flight.
REQ-014 SHALL have port err_orphan, out, 1, sticky flag for unmatched read data.

Function
REQ-015 SHALL implement states IDLE and GRANT, with grant register gnt (0 or 1) and round-robin pointer rr.
REQ-016 In IDLE, a requester SHALL be eligible when it asserts write, or asserts read while outstanding < MAX_OUTSTANDING.
REQ-017 In IDLE with an eligible requester, the block SHALL latch gnt = rr if rr is eligible, else the other requester, and SHALL enter GRANT next cycle.
REQ-018 In IDLE, s_read and s_write SHALL be 0, and both m*_waitrequest SHALL be 1.
REQ-019 In GRANT, s_* command outputs SHALL combinationally mirror requester gnt, m[gnt]_waitrequest SHALL equal s_waitrequest, and the other requester's waitrequest SHALL be 1.
REQ-020 A command SHALL be accepted in the cycle where (s_read|s_write) & !s_waitrequest in GRANT; on acceptance, rr SHALL become ~gnt and the state SHALL return to IDLE.
REQ-021 A transaction SHALL therefore take a minimum of 2 cycles: 1 arbitration cycle plus 1 or more command cycles.
REQ-022 If requester gnt deasserts read and write while in GRANT (protocol violation), the block SHALL return to IDLE without a push and without changing rr.
REQ-023 Simultaneous read and write from one requester SHALL be treated as a write only.
REQ-024 An accepted read SHALL push gnt into the tag FIFO; s_readdatavalid SHALL pop the FIFO head.
REQ-025 When the head is h, m[h]_readdatavalid SHALL be 1 in the same cycle, combinationally; readdata SHALL be broadcast to both requesters.
REQ-026 On a simultaneous push and pop, outstanding SHALL be unchanged; reads SHALL be returned in order.
REQ-027 When s_readdatavalid arrives with the FIFO empty, the data SHALL be dropped, no m*_readdatavalid SHALL assert, and err_orphan SHALL be set until reset.
REQ-028 When outstanding == MAX_OUTSTANDING, reads SHALL be ineligible while writes SHALL still be granted.

Reset
REQ-029 While reset_reset_n = 0 at a clk_clk edge: state = IDLE, gnt = 0, rr = 0, FIFO empty, outstanding = 0, err_orphan = 0.
REQ-030 During reset, s_read = s_write = 0, m*_waitrequest = 1, and m*_readdatavalid = 0.
REQ-031 Reset mid-operation SHALL discard in-flight tags; late returns SHALL be handled per REQ-027.

Structure
REQ-032 Package apollo_mem_pkg SHALL hold the ADDR_W/DATA_W defaults, the arb_state_t enum (IDLE, GRANT), and the req_id_t typedef.
REQ-033 The tag FIFO SHALL be sub-module mem_tag_fifo (width 1, depth MAX_OUTSTANDING, push/pop/full/empty/count).

Verification
REQ-034 Only m0 writes addr 0x100, s_waitrequest = 0 -> s_write high exactly 1 cycle, in the 2nd cycle after request; m0_waitrequest low that cycle.
REQ-035 m0 and m1 both request reads continuously -> grants alternate 0,1,0,1 starting with m0 after reset.
REQ-036 m1 read with s_waitrequest held 3 cycles -> s_read stable 4 cycles, m0_waitrequest = 1 throughout, exactly one push.
REQ-037 Issue 8 reads (alternating masters) with no return; 9th read stalls while a write proceeds; return 8 beats -> readdatavalid order 0,1,0,1,..., outstanding counts back to 0.
REQ-038 s_readdatavalid with empty FIFO -> no m*_readdatavalid, err_orphan = 1 until reset_reset_n = 0.
REQ-039 Reset asserted during GRANT with 2 reads outstanding -> next cycle IDLE, outstanding = 0; subsequent return sets err_orphan.
